// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency-sweep scheduler feeding the DDS compiler
// S_AXIS_CONFIG port. It emits {POFF, PINC} words that step linearly from
// inc_start by inc_step and holds each point for a programmable dwell time.
// The sweep either stops after the last point or restarts from the beginning.
module dds_sweep_ctrl #(
  parameter int PHASE_W = 16,
  parameter int DWELL_W = 32,
  parameter int PTS_W   = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   continuous,
  input  logic [PHASE_W-1:0]     inc_start,
  input  logic [PHASE_W-1:0]     inc_step,
  input  logic [PHASE_W-1:0]     poff,
  input  logic [PTS_W-1:0]       num_points,
  input  logic [DWELL_W-1:0]     dwell,
  output logic [2*PHASE_W-1:0]   m_axis_cfg_tdata,
  output logic                   m_axis_cfg_tvalid,
  input  logic                   m_axis_cfg_tready,
  output logic                   busy,
  output logic                   done,
  output logic [PTS_W-1:0]       point_idx
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;

  logic [1:0]         r_state;
  logic               r_abort;
  logic               r_done;
  logic [PTS_W-1:0]   r_point_idx;

  // Parameters captured at start; later input changes are ignored.
  logic               r_cont;
  logic [PHASE_W-1:0] r_inc_start;
  logic [PHASE_W-1:0] r_inc_step;
  logic [PHASE_W-1:0] r_poff;
  logic [PTS_W-1:0]   r_last_idx;
  logic [DWELL_W-1:0] r_dwell;

  logic [PHASE_W-1:0] r_cur_inc;
  logic [DWELL_W-1:0] r_cnt;

  logic w_accept;
  logic w_hs;
  logic w_expire;
  logic w_last;

  assign w_accept = (r_state == S_IDLE) && start && !stop;
  assign w_hs     = (r_state == S_SEND) && m_axis_cfg_tready;
  // The counter is loaded with an effective dwell of at least 1, so a value
  // of 1 marks the final dwell cycle.
  assign w_expire = (r_state == S_DWELL) && (r_cnt == DWELL_W'(1));
  assign w_last   = (r_point_idx == r_last_idx);

  // Control FSM: sequencing, abort tracking, done pulse and point index.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state     <= S_IDLE;
      r_abort     <= 1'b0;
      r_done      <= 1'b0;
      r_point_idx <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_SEND;
            r_point_idx <= '0;
            r_abort     <= 1'b0;
          end
        end
        S_SEND: begin
          // A stop here cannot retract tvalid; remember it and leave after
          // the handshake completes.
          if (stop) r_abort <= 1'b1;
          if (w_hs) begin
            if (r_abort || stop) begin
              r_state <= S_IDLE;
              r_abort <= 1'b0;
            end else begin
              r_state <= S_DWELL;
            end
          end
        end
        S_DWELL: begin
          if (stop) begin
            r_state <= S_IDLE;
          end else if (w_expire) begin
            if (!w_last) begin
              r_point_idx <= r_point_idx + PTS_W'(1);
              r_state     <= S_SEND;
            end else if (r_cont) begin
              r_point_idx <= '0;
              r_state     <= S_SEND;
            end else begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath: parameter capture, phase-increment stepping and dwell counting.
  always_ff @(posedge aclk) begin
    if (w_accept) begin
      r_cont      <= continuous;
      r_inc_start <= inc_start;
      r_inc_step  <= inc_step;
      r_poff      <= poff;
      r_last_idx  <= (num_points == '0) ? '0 : num_points - PTS_W'(1);
      r_dwell     <= (dwell == '0) ? DWELL_W'(1) : dwell;
      r_cur_inc   <= inc_start;
    end
    if (w_hs) begin
      r_cnt <= r_dwell;
    end else if (r_state == S_DWELL) begin
      r_cnt <= r_cnt - DWELL_W'(1);
    end
    if (w_expire && !stop) begin
      if (!w_last) begin
        // Modulo 2^PHASE_W: wrap-around is the intended chirp behaviour.
        r_cur_inc <= r_cur_inc + r_inc_step;
      end else if (r_cont) begin
        r_cur_inc <= r_inc_start;
      end
    end
  end

  assign m_axis_cfg_tvalid = (r_state == S_SEND);
  // Gating keeps tdata at zero outside SEND, including right after reset.
  assign m_axis_cfg_tdata  = m_axis_cfg_tvalid ? {r_poff, r_cur_inc} : '0;
  assign busy              = (r_state != S_IDLE);
  assign done              = r_done;
  assign point_idx         = r_point_idx;

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep scheduler for the DDS compiler IP. It drives the DDS `S_AXIS_CONFIG` AXI4-Stream slave with a sequence of phase-increment words (linear chirp or frequency hop ramp). Each point is held for a programmable dwell time. It sits between the control logic (buttons, UART or register block) and the `dds_wrapper` configuration port, in the same `aclk` domain as the DDS data and phase streams.

## Interface
- `PHASE_W`, default 16: DDS phase width; PINC and POFF are each PHASE_W bits.
- `DWELL_W`, default 32: dwell counter width.
- `PTS_W`, default 16: point counter width.
- `aclk  in  1`: DDS clock, same as the DDS IP `aclk`.
- `areset  in  1`: synchronous, active-high reset.
- `start  in  1`: single-cycle pulse that begins a sweep; sampled only in IDLE.
- `stop  in  1`: abort request; sampled in every state.
- `continuous  in  1`: 1 = restart the sweep after the last point; latched on start.
- `inc_start  in  PHASE_W`: first PINC; latched on start.
- `inc_step  in  PHASE_W`: per-point PINC increment, two's complement; latched on start.
- `poff  in  PHASE_W`: phase offset sent with every point; latched on start.
- `num_points  in  PTS_W`: points per sweep; 0 is treated as 1; latched on start.
- `dwell  in  DWELL_W`: cycles per point after handshake; 0 is treated as 1; latched on start.
- `m_axis_cfg_tdata  out  2*PHASE_W`: `{POFF, PINC}`, with PINC in the low half (DDS compiler packing).
- `m_axis_cfg_tvalid  out  1`: config word valid.
- `m_axis_cfg_tready  in  1`: DDS ready.
- `busy  out  1`: high in every state except IDLE.
- `done  out  1`: one-cycle pulse when a non-continuous sweep completes.
- `point_idx  out  PTS_W`: index of the current or last sent point.

## Operation
- FSM states: IDLE, SEND, DWELL.
- IDLE:
  - `start`=1 and `stop`=0: latch all inputs, cur_inc ← inc_start, point_idx ← 0, go to SEND.
  - `start` and `stop` in the same cycle: stay in IDLE (`stop` wins).
- SEND:
  - `tvalid`=1 and `tdata`={poff_l, cur_inc}, both held stable until `tvalid && tready`.
  - `tvalid` never drops before the handshake.
  - On handshake: load the dwell counter and go to DWELL, unless an abort is pending, in which case go to IDLE.
- DWELL:
  - `tvalid`=0; count dwell_l cycles.
  - On expiry, if point_idx ≠ num_points_l−1: cur_inc ← cur_inc + inc_step_l (modulo 2^PHASE_W, no saturation), point_idx+1, go to SEND.
  - On expiry at the last point with continuous_l=1: cur_inc ← inc_start_l, point_idx ← 0, go to SEND.
  - On expiry at the last point with continuous_l=0: go to IDLE and pulse `done`.
- `stop`:
  - In DWELL: go to IDLE the next cycle with no `done`.
  - In SEND: set abort_pending, complete the current handshake, then go to IDLE with no `done`.
  - Takes effect regardless of continuous mode.
- `start` while busy: ignored; latched parameters remain unchanged.
- Input changes mid-sweep have no effect until the next `start`.

## Timing
- Reset values: `tvalid`=0, `tdata`=0, `busy`=0, `done`=0, `point_idx`=0, state=IDLE.
- `areset` mid-sweep: all outputs return to reset values on the next edge, with no completion of the pending handshake.
- `start` sampled at edge 0: `tvalid` and `busy` are high in cycle 1.
- Handshake in cycle k: DWELL occupies cycles k+1..k+D (D = effective dwell), and the next SEND starts in cycle k+D+1.
- Point period with `tready` held high: D+1 cycles.
- Each cycle of `tready` low stretches the period by one cycle.
- Last DWELL cycle at cycle n: in cycle n+1, `done`=1, `busy`=0 and state=IDLE.
- A new `start` is accepted in that same cycle n+1.
- `point_idx` updates in the same cycle as the new `tdata` (entry into SEND).

## Test plan
1. **Linear sweep.** inc_start=0x0100, inc_step=0x0100, num_points=4, dwell=3, `tready`=1, `start` at cycle 0 → PINC 0x0100/0x0200/0x0300/0x0400 handshaken at cycles 1/5/9/13; `done` pulse and `busy` low at cycle 17; POFF field constant.
2. **Backpressure.** Same setup with `tready` low for cycles 5–9 → `tvalid` high and `tdata`=0x0200 stable throughout; handshake at cycle 10; subsequent points at 14 and 18; `done` at 22.
3. **Wrap-around and negative step.**
   - inc_start=0xFF00, step=0x0100, num=3 → 0xFF00, 0x0000, 0x0100.
   - inc_start=0x0010, step=0xFFF0, num=3 → 0x0010, 0x0000, 0xFFF0.
4. **Continuous mode and stop in DWELL.** num=2 (0x0040, step 0x0040), dwell=2, continuous=1 → 0x0040, 0x0080, 0x0040, 0x0080 …; no `done`. `stop` in DWELL → IDLE and `busy`=0 next cycle, no `done`.
5. **Abort and start edge cases.**
   - `stop` in SEND with `tready`=0 for 4 cycles → `tvalid` held until `tready`; IDLE one cycle after the handshake; no `done`.
   - `start` with `stop` in the same cycle → no `tvalid`.
   - `start` during a sweep → sequence unchanged.
6. **Reset and degenerate parameters.**
   - `areset` during DWELL of point 2 → next cycle: all outputs 0, `busy`=0.
   - Then num_points=0, dwell=0 → exactly one point sent, with a period of 2 cycles before `done`.
